writeback_sequencer: RTL
========================

WRITEBACK_SEQUENCER -- requirements
Module: writeback_sequencer

Interface
REQ-001 The block SHALL have one clock, clk; reset is asynchronous and active-low, rst_n.
REQ-002 Ports SHALL be, clock and reset first:
clk  in  1  sole clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  execute-stage result offered
in_ready  out  1  sequencer can accept a result
in_kill  in  1  offered instruction is a halt/kill
in_rip  in  64  offered instruction RIP
in_dest  in  4  primary destination register
in_result  in  64  primary result
in_spc_valid  in  1  special destination present
in_spc_dest  in  4  special destination register
in_spc_result  in  64  special result
in_src1_valid, in_src2_valid  in  1 each  source operand valid
in_src1, in_src2  in  4 each  source register codes
rf_we  out  1  register-file write enable, single port
rf_waddr  out  4  write address
rf_wdata  out  64  write data
sb_clr_valid  out  1  scoreboard release pulse
sb_clr_mask  out  16  registers to mark not-in-use
retire_valid  out  1  instruction retired pulse
retire_rip  out  64  RIP of the retired instruction
retired_count  out  32  retired-instruction counter
halted  out  1  sticky, kill retired

Function
REQ-003 The FSM SHALL have the states IDLE, WR_PRI, WR_SPC and HALT.
REQ-004 in_ready SHALL be 1 only in IDLE.
REQ-005 An in_valid and in_ready handshake SHALL capture all in_* fields into holding registers and move the FSM to WR_PRI on the next edge.
REQ-006 WR_PRI with kill clear: rf_we=1, rf_waddr=dest, rf_wdata=result.
REQ-007 WR_PRI exit: go to WR_SPC if spc_valid=1 and spc_dest!=dest; otherwise go to IDLE.
REQ-008 spc_valid=1 and spc_dest==dest: the special write SHALL be dropped, so the primary result wins.
REQ-009 WR_SPC: rf_we=1, rf_waddr=spc_dest, rf_wdata=spc_result; then go to IDLE.
REQ-010 The final write cycle of an instruction (WR_PRI exiting to IDLE, or WR_SPC) SHALL assert sb_clr_valid, retire_valid and retire_rip for exactly that one cycle.
REQ-011 sb_clr_mask SHALL be the OR of one-hot(dest), one-hot(spc_dest) if spc_valid, one-hot(src1) if src1_valid, and one-hot(src2) if src2_valid.
REQ-012 Overlapping mask bits SHALL simply OR together.
REQ-013 A captured kill SHALL act in WR_PRI as follows:
- rf_we=0 and no scoreboard release;
- retire_valid=1 and retire_rip driven;
- retired_count increments;
- next state HALT.
REQ-014 HALT SHALL be absorbing until reset: halted=1, in_ready=0, rf_we=0.
REQ-015 retired_count SHALL increment by 1 on every retire_valid pulse and wrap from 0xFFFFFFFF to 0.
REQ-016 Outside write cycles, rf_waddr and rf_wdata SHALL be 0, and sb_clr_mask SHALL be 0 whenever sb_clr_valid=0.
REQ-017 Latency SHALL be:
- accept to primary write: 1 cycle;
- throughput: one instruction per 2 cycles, or per 3 cycles with a special write.
REQ-018 in_valid held while in_ready=0 SHALL be ignored, and no field SHALL be captured.

Reset
REQ-019 rst_n low SHALL asynchronously force state=IDLE, all holding registers=0, retired_count=0 and halted=0.
REQ-020 While rst_n is low, all registered outputs SHALL be 0 and in_ready SHALL be 0.
REQ-021 Reset asserted mid-WR_PRI or mid-WR_SPC SHALL abort the instruction with no further write, clear or retire.
REQ-022 After rst_n deasserts, in_ready SHALL be 1 in the first cycle.

Structure
REQ-023 Package wb_seq_pkg SHALL hold:
- the state enum;
- REG_COUNT=16;
- REG_W=4;
- DATA_W=64;
- CNT_W=32.
REQ-024 The block SHALL be a single module with no sub-module; one-hot mask generation is an inline function in wb_seq_pkg.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- Plain op, dest=3, result=0xAA, no special, src1=1 valid -> next cycle rf_we=1, waddr=3, wdata=0xAA, sb_clr_mask=0x000A, retire_valid=1, retired_count=1.
- Special op, dest=0, spc_dest=2, spc_result=0x55 -> cycle1 write r0, cycle2 write r2=0x55, clear mask 0x0005 in cycle2 only, in_ready low 2 cycles.
- Collision, dest=spc_dest=7 -> single write r7=primary result, mask 0x0080, back to IDLE after 1 cycle.
- Kill -> no rf_we, retire_valid=1, halted=1 thereafter, and in_ready stays 0 for 100 cycles despite in_valid=1.
- Preload retired_count=0xFFFFFFFF through 2^32 retires, or force it in the bench -> one retire gives retired_count=0.
- Assert rst_n=0 asynchronously during WR_SPC -> outputs 0 immediately, no r2 write, in_ready=1 in the first cycle after release.

Source files
------------

// File: rtl/wb_seq_pkg.sv
// Shared types and helpers for the writeback sequencer: FSM state encoding,
// register-file geometry and the one-hot decoder used for scoreboard release.
package wb_seq_pkg;

  localparam int REG_COUNT = 16;
  localparam int REG_W     = 4;
  localparam int DATA_W    = 64;
  localparam int CNT_W     = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WR_PRI = 2'd1,
    WR_SPC = 2'd2,
    HALT   = 2'd3
  } wbState_t;

  function automatic logic [REG_COUNT-1:0] oneHot(input logic [REG_W-1:0] idx);
    oneHot      = '0;
    oneHot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/writeback_sequencer.sv
// Writeback sequencer: captures one execute result, writes primary then optional
// special destination through a single register-file port, then retires it.
module writeback_sequencer
  import wb_seq_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_kill,
  input  logic [DATA_W-1:0]    in_rip,
  input  logic [REG_W-1:0]     in_dest,
  input  logic [DATA_W-1:0]    in_result,
  input  logic                 in_spc_valid,
  input  logic [REG_W-1:0]     in_spc_dest,
  input  logic [DATA_W-1:0]    in_spc_result,
  input  logic                 in_src1_valid,
  input  logic                 in_src2_valid,
  input  logic [REG_W-1:0]     in_src1,
  input  logic [REG_W-1:0]     in_src2,
  output logic                 rf_we,
  output logic [REG_W-1:0]     rf_waddr,
  output logic [DATA_W-1:0]    rf_wdata,
  output logic                 sb_clr_valid,
  output logic [REG_COUNT-1:0] sb_clr_mask,
  output logic                 retire_valid,
  output logic [DATA_W-1:0]    retire_rip,
  output logic [CNT_W-1:0]     retired_count,
  output logic                 halted
);

  wbState_t             state, stateNext;
  logic                 hKill, hSpcValid, hSrc1Valid, hSrc2Valid;
  logic [DATA_W-1:0]    hRip, hResult, hSpcResult;
  logic [REG_W-1:0]     hDest, hSpcDest, hSrc1, hSrc2;
  logic [CNT_W-1:0]     retiredCnt;
  logic                 accept, spcNeeded;
  logic [REG_COUNT-1:0] clrMask;

  // Gating with rst_n keeps in_ready low while reset is held.
  assign in_ready  = rst_n && (state == IDLE);
  assign accept    = in_valid && in_ready;
  assign spcNeeded = hSpcValid && (hSpcDest != hDest);

  assign clrMask = oneHot(hDest)
                 | (hSpcValid  ? oneHot(hSpcDest) : '0)
                 | (hSrc1Valid ? oneHot(hSrc1)    : '0)
                 | (hSrc2Valid ? oneHot(hSrc2)    : '0);

  always_comb begin
    stateNext    = state;
    rf_we        = 1'b0;
    rf_waddr     = '0;
    rf_wdata     = '0;
    sb_clr_valid = 1'b0;
    retire_valid = 1'b0;
    case (state)
      IDLE: if (accept) stateNext = WR_PRI;
      WR_PRI: begin
        if (hKill) begin
          // A kill retires without touching the register file or scoreboard.
          retire_valid = 1'b1;
          stateNext    = HALT;
        end else begin
          rf_we    = 1'b1;
          rf_waddr = hDest;
          rf_wdata = hResult;
          if (spcNeeded) begin
            stateNext = WR_SPC;
          end else begin
            sb_clr_valid = 1'b1;
            retire_valid = 1'b1;
            stateNext    = IDLE;
          end
        end
      end
      WR_SPC: begin
        rf_we        = 1'b1;
        rf_waddr     = hSpcDest;
        rf_wdata     = hSpcResult;
        sb_clr_valid = 1'b1;
        retire_valid = 1'b1;
        stateNext    = IDLE;
      end
      default: stateNext = HALT;
    endcase
  end

  assign sb_clr_mask   = sb_clr_valid ? clrMask : '0;
  assign retire_rip    = retire_valid ? hRip : '0;
  assign retired_count = retiredCnt;
  assign halted        = (state == HALT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      retiredCnt <= '0;
    end else begin
      state <= stateNext;
      if (retire_valid) retiredCnt <= retiredCnt + 1'b1;
    end
  end

  // Holding registers: loaded only on an accepted handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hKill      <= 1'b0;
      hRip       <= '0;
      hDest      <= '0;
      hResult    <= '0;
      hSpcValid  <= 1'b0;
      hSpcDest   <= '0;
      hSpcResult <= '0;
      hSrc1Valid <= 1'b0;
      hSrc2Valid <= 1'b0;
      hSrc1      <= '0;
      hSrc2      <= '0;
    end else if (accept) begin
      hKill      <= in_kill;
      hRip       <= in_rip;
      hDest      <= in_dest;
      hResult    <= in_result;
      hSpcValid  <= in_spc_valid;
      hSpcDest   <= in_spc_dest;
      hSpcResult <= in_spc_result;
      hSrc1Valid <= in_src1_valid;
      hSrc2Valid <= in_src2_valid;
      hSrc1      <= in_src1;
      hSrc2      <= in_src2;
    end
  end

endmodule
